// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the EX-stage forwarding/hazard controller: select encodings and the
// destination-register shadow slot carried down the pipeline.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned RegAw = 5;

  typedef logic [1:0] fw_sel_t;

  localparam fw_sel_t FW_SEL_IDREG = 2'b00;
  localparam fw_sel_t FW_SEL_MEMWB = 2'b01;
  localparam fw_sel_t FW_SEL_EXMEM = 2'b10;

  localparam logic [RegAw-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic             valid;
    logic [RegAw-1:0] rd;
    logic             regwrite;
    logic             memread;
  } slot_t;

  // $0 is hard-wired, so a write to it never produces a value worth forwarding.
  function automatic logic slot_writes(slot_t s, logic [RegAw-1:0] r);
    return s.valid & s.regwrite & (s.rd == r) & (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction fields in, forwarding selects / stall status out.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_uses_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              flush_i;
  logic [1:0]        fw_a_o;
  logic [1:0]        fw_b_o;
  logic              stall_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i, id_rd_i, id_regwrite_i, id_memread_i,
    output flush_i,
    input  fw_a_o, fw_b_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_uses_rt_i, id_rd_i, id_regwrite_i, id_memread_i,
    input  flush_i,
    output fw_a_o, fw_b_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_match.sv
// Compares one source register against the EX and MEM shadow slots and picks the forwarding
// select; the EX slot is the younger producer and wins.
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [RegAw-1:0] src_i,
  input  slot_t            ex_slot_i,
  input  slot_t            mem_slot_i,
  output fw_sel_t          sel_o
);

  always_comb begin
    sel_o = FW_SEL_IDREG;
    if (slot_writes(ex_slot_i, src_i)) begin
      sel_o = FW_SEL_EXMEM;
    end else if (slot_writes(mem_slot_i, src_i)) begin
      sel_o = FW_SEL_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select generator and load-use stall detector. Selects are registered one cycle
// ahead so they are stable when the instruction reaches EX.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAw,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  fwd_hazard_ctrl_if.slave  bus
);

  slot_t            ex_q, mem_q, id_slot;
  fw_sel_t          fw_a_q, fw_b_q, sel_a, sel_b;
  logic [CNT_W-1:0] cnt_q;
  logic [REG_AW-1:0] rs, rt;
  logic             stall, bubble, ex_hit;

  assign rs = bus.id_rs_i;
  assign rt = bus.id_rt_i;

  assign id_slot = '{valid:    1'b1,
                     rd:       bus.id_rd_i,
                     regwrite: bus.id_regwrite_i,
                     memread:  bus.id_memread_i};

  // Load result only exists at the end of MEM, so a consumer right behind it must wait.
  assign ex_hit = (ex_q.rd == rs) | (bus.id_uses_rt_i & (ex_q.rd == rt));
  assign stall  = bus.id_valid_i & ~bus.flush_i & ex_q.valid & ex_q.memread & ex_q.regwrite &
                  (ex_q.rd != REG_ZERO) & ex_hit;
  assign bubble = stall | bus.flush_i | ~bus.id_valid_i;

  fwd_match u_match_a (
    .src_i      (rs),
    .ex_slot_i  (ex_q),
    .mem_slot_i (mem_q),
    .sel_o      (sel_a)
  );

  fwd_match u_match_b (
    .src_i      (rt),
    .ex_slot_i  (ex_q),
    .mem_slot_i (mem_q),
    .sel_o      (sel_b)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q   <= '0;
      mem_q  <= '0;
      fw_a_q <= FW_SEL_IDREG;
      fw_b_q <= FW_SEL_IDREG;
      cnt_q  <= '0;
    end else begin
      mem_q  <= ex_q;
      ex_q   <= bubble ? '0 : id_slot;
      fw_a_q <= bubble ? FW_SEL_IDREG : sel_a;
      fw_b_q <= (bubble | ~bus.id_uses_rt_i) ? FW_SEL_IDREG : sel_b;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fw_a_o      = fw_a_q;
  assign bus.fw_b_o      = fw_b_q;
  assign bus.stall_o     = stall;
  assign bus.stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed instruction sequences with hand-computed selects, stall and stall count.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one instruction in ID: valid, rs, rt, uses_rt, rd, regwrite, memread, flush.
  task automatic id_set(input logic v, input int rs, input int rt, input logic urt,
                        input int rd, input logic rw, input logic mr, input logic fl);
    bus.id_valid_i    = v;
    bus.id_rs_i       = 5'(rs);
    bus.id_rt_i       = 5'(rt);
    bus.id_uses_rt_i  = urt;
    bus.id_rd_i       = 5'(rd);
    bus.id_regwrite_i = rw;
    bus.id_memread_i  = mr;
    bus.flush_i       = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_fw_a", 32'(bus.fw_a_o), 0);
    check("rst_fw_b", 32'(bus.fw_b_o), 0);
    check("rst_stall", 32'(bus.stall_o), 0);
    check("rst_cnt", 32'(bus.stall_cnt_o), 0);
    rst = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    id_set(1, 1, 2, 1, 3, 1, 0, 0); step();
    id_set(1, 3, 5, 1, 4, 1, 0, 0);
    check("exmem_stall", 32'(bus.stall_o), 0);
    step();
    check("exmem_fw_a", 32'(bus.fw_a_o), 2);
    check("exmem_fw_b", 32'(bus.fw_b_o), 0);

    // add $3 ; nop ; and $6,$3,$3
    id_set(1, 1, 2, 1, 3, 1, 0, 0); step();
    id_set(0, 0, 0, 0, 0, 0, 0, 0); step();
    id_set(1, 3, 3, 1, 6, 1, 0, 0); step();
    check("memwb_fw_a", 32'(bus.fw_a_o), 1);
    check("memwb_fw_b", 32'(bus.fw_b_o), 1);

    // lw $2,0($1) ; add $4,$2,$2
    id_set(1, 1, 2, 0, 2, 1, 1, 0); step();
    id_set(1, 2, 2, 1, 4, 1, 0, 0);
    check("lu_stall", 32'(bus.stall_o), 1);
    step();
    check("lu_cnt", 32'(bus.stall_cnt_o), 1);
    check("lu_bubble_fw_a", 32'(bus.fw_a_o), 0);
    check("lu_stall_once", 32'(bus.stall_o), 0);
    step();
    check("lu_reissue_fw_a", 32'(bus.fw_a_o), 1);
    check("lu_reissue_fw_b", 32'(bus.fw_b_o), 1);
    check("lu_cnt_hold", 32'(bus.stall_cnt_o), 1);

    // add $0,$1,$1 ; or $5,$0,$0
    id_set(1, 1, 1, 1, 0, 1, 0, 0); step();
    id_set(1, 0, 0, 1, 5, 1, 0, 0);
    check("r0_stall", 32'(bus.stall_o), 0);
    step();
    check("r0_fw_a", 32'(bus.fw_a_o), 0);
    check("r0_fw_b", 32'(bus.fw_b_o), 0);

    // lw $7 ; consumer of $7 flushed ; then a fresh consumer sees the load in MEM
    id_set(1, 1, 0, 0, 7, 1, 1, 0); step();
    id_set(1, 7, 7, 1, 9, 1, 0, 1);
    check("fl_stall", 32'(bus.stall_o), 0);
    step();
    check("fl_fw_a", 32'(bus.fw_a_o), 0);
    check("fl_cnt", 32'(bus.stall_cnt_o), 1);
    id_set(1, 7, 0, 0, 10, 1, 0, 0);
    check("fl_bubble_nostall", 32'(bus.stall_o), 0);
    step();
    check("fl_after_fw_a", 32'(bus.fw_a_o), 1);

    // add $3 ; sub $3 ; xor $8,$3,$9
    id_set(1, 1, 2, 1, 3, 1, 0, 0); step();
    id_set(1, 4, 5, 1, 3, 1, 0, 0); step();
    id_set(1, 3, 9, 1, 8, 1, 0, 0); step();
    check("young_fw_a", 32'(bus.fw_a_o), 2);
    check("young_fw_b", 32'(bus.fw_b_o), 0);

    // Reset asserted during a load-use stall
    id_set(1, 1, 0, 0, 2, 1, 1, 0); step();
    id_set(1, 2, 0, 0, 4, 1, 0, 0);
    check("rs_stall_pre", 32'(bus.stall_o), 1);
    rst = 1'b1;
    step();
    check("rs_stall", 32'(bus.stall_o), 0);
    check("rs_fw_a", 32'(bus.fw_a_o), 0);
    check("rs_fw_b", 32'(bus.fw_b_o), 0);
    check("rs_cnt", 32'(bus.stall_cnt_o), 0);
    rst = 1'b0;
    step();
    check("rs_reeval_fw_a", 32'(bus.fw_a_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
